// File: rtl/spi_master_arbiter.sv
// Shares one SPI byte driver among NUM_REQ requesters; SPI_ARB_FIXED_PRIO_EN selects fixed lowest-index priority.
// m_start_o one cycle after req is seen, done_o one cycle after driver busy falls; losers simply wait, no pre-emption.
module spi_master_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic [NUM_REQ-1:0]   req_i,
  input  logic [NUM_REQ-1:0]   lock_i,
  input  logic [8*NUM_REQ-1:0] wdata_bi,
  output logic [NUM_REQ-1:0]   gnt_bo,
  output logic [NUM_REQ-1:0]   done_o,
  output logic [7:0]           rdata_bo,
  output logic                 err_o,
  output logic                 m_start_o,
  output logic [7:0]           m_data_bo,
  input  logic                 m_busy_i,
  input  logic [7:0]           m_data_bi
);
  localparam int IDX_W = $clog2(NUM_REQ);

  typedef enum logic [2:0] {IDLE, START, WAIT_BUSY, WAIT_DONE, DONE} state_t;

  state_t             r_state;
  logic [IDX_W-1:0]   r_win;
  logic [7:0]         r_cnt;
  logic [NUM_REQ-1:0] r_gnt;
  logic [NUM_REQ-1:0] r_done;
  logic [7:0]         r_rdata;
  logic               r_err;
  logic               r_start;
`ifndef SPI_ARB_FIXED_PRIO_EN
  logic [IDX_W-1:0]   r_ptr;
`endif

  logic [IDX_W-1:0]   w_win;

  // Descending scan so the last hit is the first in search order.
  always_comb begin
    w_win = '0;
`ifdef SPI_ARB_FIXED_PRIO_EN
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_i[i]) w_win = IDX_W'(i);
    end
`else
    for (int i = NUM_REQ; i >= 1; i--) begin
      if (req_i[(int'(r_ptr) + i) % NUM_REQ]) w_win = IDX_W'((int'(r_ptr) + i) % NUM_REQ);
    end
`endif
  end

  assign gnt_bo    = r_gnt;
  assign done_o    = r_done;
  assign rdata_bo  = r_rdata;
  assign err_o     = r_err;
  assign m_start_o = r_start;
  // Byte is taken live during START so a locked burst can present it right after done_o.
  assign m_data_bo = (r_state == START) ? wdata_bi[int'(r_win)*8 +: 8] : 8'h00;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= IDLE;
      r_win   <= '0;
      r_cnt   <= '0;
      r_gnt   <= '0;
      r_done  <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
      r_start <= 1'b0;
`ifndef SPI_ARB_FIXED_PRIO_EN
      r_ptr   <= IDX_W'(NUM_REQ - 1);
`endif
    end else begin
      case (r_state)
        IDLE: begin
          r_err  <= 1'b0;
          r_done <= '0;
          if (|req_i) begin
            r_win   <= w_win;
            r_gnt   <= NUM_REQ'(1) << w_win;
            r_start <= 1'b1;
            r_state <= START;
          end
        end
        START: begin
          r_start <= 1'b0;
          r_cnt   <= '0;
          r_state <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (m_busy_i) begin
            r_state <= WAIT_DONE;
          end else if (r_cnt == 8'(TIMEOUT - 1)) begin
            r_cnt   <= r_cnt + 8'd1;
            r_err   <= 1'b1;
            r_gnt   <= '0;
`ifndef SPI_ARB_FIXED_PRIO_EN
            r_ptr   <= r_win;
`endif
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        WAIT_DONE: begin
          if (!m_busy_i) begin
            r_rdata <= m_data_bi;
            r_done  <= NUM_REQ'(1) << r_win;
            r_state <= DONE;
          end
        end
        DONE: begin
          r_done <= '0;
          if (lock_i[r_win] && req_i[r_win]) begin
            r_start <= 1'b1;
            r_state <= START;
          end else begin
            r_gnt   <= '0;
`ifndef SPI_ARB_FIXED_PRIO_EN
            r_ptr   <= r_win;
`endif
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_master_arbiter.sv
// Scoreboard bench for spi_master_arbiter with a behavioural byte driver (MISO = MOSI ^ key).
module tb_spi_master_arbiter;
  localparam int NUM_REQ  = 4;
  localparam int TIMEOUT  = 15;
  localparam int BUSY_LEN = 4;

  typedef struct packed {
    logic       is_err;
    logic [3:0] done;
    logic [7:0] rdata;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [3:0]  lock;
  logic [31:0] wdata;
  logic [3:0]  gnt_bo;
  logic [3:0]  done_o;
  logic [7:0]  rdata_bo;
  logic        err_o;
  logic        m_start_o;
  logic [7:0]  m_data_bo;
  logic        m_busy;
  logic [7:0]  m_miso;

  logic        drv_en;
  logic [7:0]  key;
  exp_t        sb_q[$];
  int          n_chk  = 0;
  int          n_pass = 0;
  int          n_viol = 0;

  always #5 clk = ~clk;

  spi_master_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .req_i(req), .lock_i(lock), .wdata_bi(wdata),
    .gnt_bo(gnt_bo), .done_o(done_o), .rdata_bo(rdata_bo), .err_o(err_o),
    .m_start_o(m_start_o), .m_data_bo(m_data_bo), .m_busy_i(m_busy), .m_data_bi(m_miso)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic wait_done(input logic [3:0] mask, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if ((done_o & mask) != 4'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Driver model: busy rises at the start cycle, falls BUSY_LEN cycles later with the reply byte.
  initial begin
    logic [7:0] b;
    m_busy = 1'b0;
    m_miso = 8'h00;
    forever begin
      @(negedge clk);
      if (rst_n && drv_en && m_start_o) begin
        b = m_data_bo;
        m_busy = 1'b1;
        for (int i = 0; i < BUSY_LEN; i++) begin
          @(negedge clk);
          if (!rst_n) break;
        end
        m_busy = 1'b0;
        if (rst_n) m_miso = b ^ key;
      end
    end
  end

  // Monitor: pops one expectation per done/err pulse.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if ($countones(gnt_bo) > 1) n_viol++;
      if (m_start_o && gnt_bo == 4'b0) n_viol++;
      if (done_o != 4'b0 || err_o) begin
        if (sb_q.size() == 0) begin
          check("sb_unexpected", 32'({done_o, err_o}), 32'h0);
        end else begin
          e = sb_q.pop_front();
          check("sb_err",   32'(err_o),    32'(e.is_err));
          check("sb_done",  32'(done_o),   32'(e.done));
          check("sb_gnt",   32'(gnt_bo),   e.is_err ? 32'h0 : 32'(e.done));
          check("sb_rdata", 32'(rdata_bo), 32'(e.rdata));
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit         ok;
    int         j;
    int         n_st;
    logic [3:0] t2_gnt[5];
    logic [7:0] t2_dat[5];

    rst_n = 1'b0; req = '0; lock = '0; wdata = '0; drv_en = 1'b1; key = 8'h00;
    repeat (2) @(negedge clk);
    check("rst_gnt",   32'(gnt_bo),    32'h0);
    check("rst_done",  32'(done_o),    32'h0);
    check("rst_err",   32'(err_o),     32'h0);
    check("rst_start", 32'(m_start_o), 32'h0);
    check("rst_mdata", 32'(m_data_bo), 32'h0);
    check("rst_rdata", 32'(rdata_bo),  32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single requester 1, loopback.
    wdata[15:8] = 8'hA5;
    sb_q.push_back('{1'b0, 4'b0010, 8'hA5});
    req = 4'b0010;
    @(negedge clk);
    check("t1_start", 32'(m_start_o), 32'h1);
    check("t1_gnt",   32'(gnt_bo),    32'h2);
    check("t1_mdata", 32'(m_data_bo), 32'hA5);
    wait_done(4'b0010, ok);
    check("t1_done_seen", 32'(ok), 32'h1);
    req = 4'b0;
    @(negedge clk);
    check("t1_gnt_clear", 32'(gnt_bo), 32'h0);

    // All four requesting, no lock.
    do_reset();
    wdata = {8'h43, 8'h32, 8'h21, 8'h10};
`ifdef SPI_ARB_FIXED_PRIO_EN
    t2_gnt = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
    t2_dat = '{8'h10, 8'h10, 8'h10, 8'h10, 8'h10};
`else
    t2_gnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    t2_dat = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h10};
`endif
    for (int k = 0; k < 5; k++) sb_q.push_back('{1'b0, t2_gnt[k], t2_dat[k]});
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_done(4'b1111, ok);
      check("t2_done_seen", 32'(ok), 32'h1);
    end
    req = 4'b0;
    repeat (3) @(negedge clk);
    check("t2_sb_empty", 32'(sb_q.size()), 32'h0);

    // Locked burst on requester 2 while requester 0 waits; slave inverts.
    do_reset();
    key = 8'hFF;
    wdata[23:16] = 8'h11;
    wdata[7:0]   = 8'h5A;
    sb_q.push_back('{1'b0, 4'b0100, 8'hEE});
    sb_q.push_back('{1'b0, 4'b0100, 8'hDD});
    sb_q.push_back('{1'b0, 4'b0100, 8'hCC});
    sb_q.push_back('{1'b0, 4'b0001, 8'hA5});
    lock = 4'b0100;
    req  = 4'b0100;
    @(negedge clk);
    check("t3_first_gnt", 32'(gnt_bo), 32'h4);
    req[0] = 1'b1;
    wait_done(4'b0100, ok);
    check("t3_done1", 32'(ok), 32'h1);
    wdata[23:16] = 8'h22;
    wait_done(4'b0100, ok);
    check("t3_done2", 32'(ok), 32'h1);
    wdata[23:16] = 8'h33;
    wait_done(4'b0100, ok);
    check("t3_done3", 32'(ok), 32'h1);
    lock = 4'b0;
    req[2] = 1'b0;
    wait_done(4'b0001, ok);
    check("t3_done_r0", 32'(ok), 32'h1);
    req = 4'b0;
    repeat (3) @(negedge clk);
    check("t3_sb_empty", 32'(sb_q.size()), 32'h0);

    // Busy never rises: timeout on requester 3, then requester 0 wins.
    key = 8'h00;
    drv_en = 1'b0;
    wdata[31:24] = 8'h77;
    sb_q.push_back('{1'b1, 4'b0000, 8'hA5});
    req = 4'b1000;
    @(negedge clk);
    check("t4_start", 32'(m_start_o), 32'h1);
    check("t4_gnt",   32'(gnt_bo),    32'h8);
    j = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (err_o) begin
        j = i;
        break;
      end
    end
    check("t4_err_delay", 32'(j), 32'd16);
    drv_en = 1'b1;
    sb_q.push_back('{1'b0, 4'b0001, 8'h5A});
    req = 4'b1001;
    @(negedge clk);
    check("t4_next_gnt", 32'(gnt_bo), 32'h1);
    req = 4'b0001;
    wait_done(4'b0001, ok);
    check("t4_done_r0", 32'(ok), 32'h1);
    req = 4'b0;
    repeat (2) @(negedge clk);

    // Asynchronous reset in the middle of WAIT_DONE.
    wdata[15:8] = 8'h3C;
    req = 4'b0010;
    @(negedge clk);
    check("t5_start", 32'(m_start_o), 32'h1);
    repeat (2) @(negedge clk);
    check("t5_gnt_before", 32'(gnt_bo), 32'h2);
    #1 rst_n = 1'b0;
    #1;
    check("t5_rst_gnt",   32'(gnt_bo),    32'h0);
    check("t5_rst_start", 32'(m_start_o), 32'h0);
    check("t5_rst_done",  32'(done_o),    32'h0);
    check("t5_rst_rdata", 32'(rdata_bo),  32'h0);
    repeat (3) @(negedge clk);
    sb_q.push_back('{1'b0, 4'b0010, 8'h3C});
    rst_n = 1'b1;
    @(negedge clk);
    check("t5_first_gnt", 32'(gnt_bo),    32'h2);
    check("t5_restart",   32'(m_start_o), 32'h1);
    wait_done(4'b0010, ok);
    check("t5_done_seen", 32'(ok), 32'h1);
    req = 4'b0;
    repeat (2) @(negedge clk);

    // Request dropped while the transfer is in flight.
    wdata[7:0] = 8'h96;
    sb_q.push_back('{1'b0, 4'b0001, 8'h96});
    req = 4'b0001;
    @(negedge clk);
    check("t6_start", 32'(m_start_o), 32'h1);
    repeat (2) @(negedge clk);
    req = 4'b0;
    wait_done(4'b0001, ok);
    check("t6_done_seen", 32'(ok), 32'h1);
    n_st = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (m_start_o) n_st++;
    end
    check("t6_no_restart", 32'(n_st),   32'h0);
    check("t6_gnt_idle",   32'(gnt_bo), 32'h0);

    check("sb_empty",   32'(sb_q.size()), 32'h0);
    check("gnt_onehot", 32'(n_viol),      32'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
